// File: rtl/ir_carrier_pwm.sv
// IR carrier generator: accepts a half-period value through a strobe/ack write
// handshake and drives a 50% duty carrier, a forced active level, or the idle level.
module ir_carrier_pwm #(
    parameter int   PWM_BITS   = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                clock_in,
    input  logic                reset_n_in,
    input  logic                enable_in,
    input  logic                forced_in,
    input  logic                wr_strobe_in,
    input  logic [PWM_BITS-1:0] value_in,
    output logic                wr_ack_out,
    output logic                pwm_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_FORCED
    } state_t;

    state_t              state;
    logic                strobe_q;
    logic                pending_valid;
    logic [PWM_BITS-1:0] pending_value;
    logic [PWM_BITS-1:0] active_value;
    logic [PWM_BITS-1:0] half_count;

    logic                write_accept;
    logic                carrier_ready;
    logic                in_carrier;
    logic                reload;
    logic                take_pending;
    logic [PWM_BITS-1:0] next_value;

    assign write_accept  = wr_strobe_in & ~strobe_q;
    assign carrier_ready = pending_valid | (active_value != '0);
    assign next_value    = pending_valid ? pending_value : active_value;

    // A pending value only reaches the active register from idle or at a
    // half-period boundary, so a running half always finishes with its old value.
    always_comb begin
        in_carrier   = 1'b0;
        reload       = 1'b0;
        take_pending = 1'b0;
        in_carrier   = (state == S_HIGH) || (state == S_LOW);
        reload       = in_carrier && enable_in && !forced_in && (half_count == '0);
        take_pending = pending_valid && ((state == S_IDLE) || reload);
    end

    // NOTE: every register, including the value holders, is cleared by the
    // asynchronous reset so a reset mid-carrier returns pwm_out to idle at once.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state         <= S_IDLE;
            strobe_q      <= 1'b0;
            pending_valid <= 1'b0;
            pending_value <= '0;
            active_value  <= '0;
            half_count    <= '0;
            wr_ack_out    <= 1'b0;
            pwm_out       <= IDLE_LEVEL;
        end else begin
            strobe_q   <= wr_strobe_in;
            wr_ack_out <= write_accept;

            if (take_pending) begin
                active_value  <= pending_value;
                pending_valid <= 1'b0;
            end
            // A write in the same cycle as a transfer wins: it stays pending.
            if (write_accept) begin
                pending_value <= value_in;
                pending_valid <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    half_count <= '0;
                    if (forced_in) begin
                        state   <= S_FORCED;
                        pwm_out <= ~IDLE_LEVEL;
                    end else if (enable_in && carrier_ready) begin
                        state      <= S_HIGH;
                        half_count <= next_value;
                        pwm_out    <= ~IDLE_LEVEL;
                    end else begin
                        pwm_out <= IDLE_LEVEL;
                    end
                end

                S_HIGH, S_LOW: begin
                    if (forced_in) begin
                        state      <= S_FORCED;
                        half_count <= '0;
                        pwm_out    <= ~IDLE_LEVEL;
                    end else if (!enable_in) begin
                        state      <= S_IDLE;
                        half_count <= '0;
                        pwm_out    <= IDLE_LEVEL;
                    end else if (reload) begin
                        state      <= (state == S_HIGH) ? S_LOW : S_HIGH;
                        half_count <= next_value;
                        pwm_out    <= ~pwm_out;
                    end else begin
                        half_count <= half_count - 1'b1;
                    end
                end

                S_FORCED: begin
                    half_count <= '0;
                    if (forced_in) begin
                        pwm_out <= ~IDLE_LEVEL;
                    end else begin
                        state   <= S_IDLE;
                        pwm_out <= IDLE_LEVEL;
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    half_count <= '0;
                    pwm_out    <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ir_carrier_pwm.sv
// Self-checking bench for ir_carrier_pwm: a per-cycle vector table for the
// handshake and a short carrier, plus directed sequences for the long corner cases.
module tb_ir_carrier_pwm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       forced;
    logic       strobe;
    logic [7:0] value;
    logic       ack;
    logic       pwm;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ir_carrier_pwm #(
        .PWM_BITS  (8),
        .IDLE_LEVEL(1'b0)
    ) dut (
        .clock_in    (clk),
        .reset_n_in  (rst_n),
        .enable_in   (enable),
        .forced_in   (forced),
        .wr_strobe_in(strobe),
        .value_in    (value),
        .wr_ack_out  (ack),
        .pwm_out     (pwm)
    );

    typedef struct {
        logic       en;
        logic       frc;
        logic       str;
        logic [7:0] val;
        logic       exp_pwm;
        logic       exp_ack;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Wait for one clock edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count how long pwm stays at lvl; the caller has already seen 'start'
    // samples at that level. Returns with the first differing sample taken.
    task automatic measure(input logic lvl, input int start, output int n);
        n = start;
        for (int k = 0; k < 600; k++) begin
            step();
            if (pwm !== lvl) return;
            n++;
        end
    endtask

    task automatic write_value(input logic [7:0] v);
        strobe = 1'b1;
        value  = v;
        step();
        strobe = 1'b0;
    endtask

    initial begin
        int n;
        int bad;

        // Value 3 with the strobe held 5 cycles, then a 4/4 carrier, then
        // enable drop, forced entry and forced release.
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};

        rst_n  = 1'b0;
        enable = 1'b0;
        forced = 1'b0;
        strobe = 1'b0;
        value  = 8'd0;

        repeat (3) step();
        check("reset_pwm", pwm, 0);
        check("reset_ack", ack, 0);
        rst_n = 1'b1;
        step();

        // Enable with no value ever written: stays idle.
        enable = 1'b1;
        bad = 0;
        repeat (6) begin
            step();
            if (pwm !== 1'b0) bad++;
        end
        check("enable_no_write_pwm_low_cycles_bad", bad, 0);
        enable = 1'b0;
        step();

        for (int i = 0; i < 17; i++) begin
            enable = vecs[i].en;
            forced = vecs[i].frc;
            strobe = vecs[i].str;
            value  = vecs[i].val;
            step();
            check($sformatf("vec%0d_pwm", i), pwm, vecs[i].exp_pwm);
            check($sformatf("vec%0d_ack", i), ack, vecs[i].exp_ack);
        end
        enable = 1'b0;
        forced = 1'b0;
        strobe = 1'b0;
        step();

        // V=104: one-cycle ack, then 105 high / 105 low.
        strobe = 1'b1;
        value  = 8'd104;
        step();
        check("v104_ack_high", ack, 1);
        strobe = 1'b0;
        step();
        check("v104_ack_one_cycle", ack, 0);
        enable = 1'b1;
        step();
        check("v104_enable_latency", pwm, 1);
        measure(1'b1, 1, n);
        check("v104_high_half", n, 105);
        measure(1'b0, 1, n);
        check("v104_low_half", n, 105);
        measure(1'b1, 1, n);
        check("v104_second_high_half", n, 105);
        enable = 1'b0;
        step();
        check("enable_drop_idle", pwm, 0);

        // Rewrite mid-carrier: V=10 running, write 2 at clock 3 of a high half.
        write_value(8'd10);
        step();
        enable = 1'b1;
        step();
        check("rewrite_start_high", pwm, 1);
        step();
        step();
        strobe = 1'b1;
        value  = 8'd2;
        step();
        strobe = 1'b0;
        n = 3;
        if (pwm === 1'b1) n = 4;
        measure(1'b1, n, n);
        check("rewrite_current_half_old_value", n, 11);
        measure(1'b0, 1, n);
        check("rewrite_next_low_half", n, 3);
        measure(1'b1, 1, n);
        check("rewrite_next_high_half", n, 3);
        enable = 1'b0;
        step();

        // Forced priority over a running V=7 carrier, entered during a low half.
        write_value(8'd7);
        step();
        enable = 1'b1;
        step();
        measure(1'b1, 1, n);
        check("v7_high_half", n, 8);
        check("v7_now_low", pwm, 0);
        forced = 1'b1;
        step();
        check("forced_next_cycle_high", pwm, 1);
        bad = 0;
        repeat (20) begin
            step();
            if (pwm !== 1'b1) bad++;
        end
        check("forced_steady_cycles_bad", bad, 0);
        forced = 1'b0;
        enable = 1'b0;
        step();
        check("forced_release_idle", pwm, 0);

        // V=0: must be enabled while the write is still pending.
        write_value(8'd0);
        enable = 1'b1;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (pwm !== ((k % 2) == 0)) bad++;
        end
        check("v0_toggle_every_clock_bad", bad, 0);
        enable = 1'b0;
        step();

        // Asynchronous reset mid-carrier while an ack is showing.
        write_value(8'd5);
        enable = 1'b1;
        step();
        check("async_pre_pwm", pwm, 1);
        strobe = 1'b1;
        value  = 8'd6;
        step();
        strobe = 1'b0;
        check("async_pre_ack", ack, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_pwm", pwm, 0);
        check("async_reset_ack", ack, 0);
        step();
        enable = 1'b0;
        #2 rst_n = 1'b1;
        step();
        check("post_reset_idle", pwm, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
